// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-register arbiter controller.
//   state_t   : controller FSM states (IDLE / SHIFT)
//   mode_t    : universal shift register operation select
//   DEF_WIDTH : default register width
//   rr_pick   : two-way round-robin winner select
package shift_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t HOLD = 2'b00;
  localparam mode_t SHR  = 2'b01;
  localparam mode_t SHL  = 2'b10;
  localparam mode_t LOAD = 2'b11;

  localparam int DEF_WIDTH = 4;

  // Returns the index of the winning requester. With a single request the
  // requester wins outright; on a tie the one not granted last time wins.
  // Result is a don't-care when neither request is high.
  function automatic logic rr_pick(input logic r0, input logic r1,
                                   input logic last);
    logic w;
    w = 1'b0;
    if (r0 && r1) w = ~last;
    else if (r1)  w = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/universal_shift_reg.sv
// Parameterized universal shift register.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears q
//   mode  : HOLD / SHR (toward bit 0) / SHL (toward MSB) / LOAD
//   din   : parallel load word
//   sin   : serial fill bit for either shift direction
//   q     : register contents
//   q_bar : bitwise inverse of q
module universal_shift_reg
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (mode)
        HOLD:    q <= q;
        SHR:     q <= {sin, q[WIDTH-1:1]};
        SHL:     q <= {q[WIDTH-2:0], sin};
        LOAD:    q <= din;
        default: q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/shift_reg_arbiter_ctrl.sv
// Round-robin controller sharing one shift register between two parallel
// producers and a single serial sink. A granted word is parallel-loaded,
// then shifted out LSB first over WIDTH cycles.
//   clk, rst        : clock, asynchronous active-high reset
//   req0/req1       : transfer requests, held until granted
//   din0/din1       : request words, sampled in the grant cycle
//   gnt0/gnt1       : one-cycle grant pulses (combinational on req)
//   sout/sout_valid : serial bit (q[0]) and its qualifier
//   owner           : requester whose word is shifting, 0 when idle
//   busy            : high while shifting
//   q/q_bar         : register contents and inverse
module shift_reg_arbiter_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sout,
  output logic             sout_valid,
  output logic             owner,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic             last_gnt;   // index of the requester granted last
  logic             own;
  logic [CW-1:0]    bit_cnt;
  logic             win;
  logic             grant;
  logic             last_bit;
  mode_t            mode;
  logic [WIDTH-1:0] load_word;

  // Arbitration is only live in IDLE; the rst gate keeps the Mealy grant
  // outputs quiet while the FSM is being held in reset.
  assign win      = rr_pick(req0, req1, last_gnt);
  assign grant    = (state == IDLE) && (req0 || req1) && !rst;
  assign last_bit = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));

  assign gnt0 = grant && !win;
  assign gnt1 = grant &&  win;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = SHIFT;
      SHIFT:   if (last_bit)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register operation: load on grant, shift right every SHIFT cycle,
  // otherwise hold. Zero fill empties the register by the last shift edge.
  always_comb begin
    mode      = HOLD;
    load_word = din0;
    if (grant) begin
      mode      = LOAD;
      load_word = win ? din1 : din0;
    end else if (state == SHIFT) begin
      mode = SHR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;   // requester 0 wins the first tie
      own      <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_gnt <= win;
        own      <= win;
        bit_cnt  <= '0;
      end else if (state == SHIFT) begin
        if (last_bit) begin
          own     <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  universal_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .din   (load_word),
    .sin   (1'b0),
    .q     (q),
    .q_bar (q_bar)
  );

  assign sout       = q[0];
  assign sout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign owner      = own;

endmodule

// File: doc/shift_reg_arbiter_ctrl.md
# shift_reg_arbiter_ctrl

Round-robin controller sharing one 4-bit shift register between two parallel-word requesters. It grants one requester, parallel-loads its word, then shifts the word out serially, LSB first, over WIDTH cycles. It sits between two parallel producers and a single serial sink. It reuses the team's 4-bit register with the same q/q_bar outputs.

## Interface
- WIDTH, 4, register width; legal range 2..16
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 wants a transfer; held high until gnt0
- din0  input  WIDTH  requester 0 word; sampled in the gnt0 cycle
- req1  input  1  requester 1 request; same rules as req0
- din1  input  WIDTH  requester 1 word
- gnt0  output  1  one-cycle grant/accept pulse to requester 0
- gnt1  output  1  one-cycle grant/accept pulse to requester 1
- sout  output  1  serial data out, equal to q[0]
- sout_valid  output  1  high during each of the WIDTH shift cycles
- owner  output  1  index of the requester whose word is shifting; 0 when idle
- busy  output  1  high while in SHIFT
- q  output  WIDTH  register contents
- q_bar  output  WIDTH  bitwise inverse of q

## Operation
- FSM states:
  - IDLE: next state is SHIFT if any req is high, otherwise IDLE.
  - SHIFT: next state is IDLE when bit_cnt == WIDTH-1, otherwise SHIFT.
- Arbitration happens only in IDLE and uses a 1-bit last-grant pointer.
  - One request high: that requester is granted.
  - Both high: the requester other than the last-granted one wins.
  - The pointer resets to 1, so requester 0 wins the first tie.
- gnt0 and gnt1 are Mealy outputs: asserted in the IDLE cycle where the grant is decided, gated low while rst=1, and never both high.
- Grant cycle edge actions:
  - register loads the granted din (mode LOAD);
  - pointer updates;
  - owner latches;
  - bit_cnt clears to 0.
- SHIFT cycle actions:
  - sout = q[0] and sout_valid = 1;
  - at each edge the register shifts right with zero fill (mode SHR) and bit_cnt increments.
- After the last shift edge, q = 0, state = IDLE, and owner = 0.
- In IDLE with no request, the register holds (mode HOLD).
- Requests arriving during SHIFT are not granted. They must stay high and are arbitrated in the next IDLE cycle.
- Dropping a req before its grant is legal; that request is simply abandoned.
- bit_cnt width is clog2(WIDTH).

## Timing
- Reset values:
  - state IDLE, q = 0, q_bar = all ones, pointer = 1, bit_cnt = 0;
  - gnt0, gnt1, sout, sout_valid, busy, owner all 0.
- Reset asserted mid-transfer takes effect immediately (asynchronously): outputs return to reset values within the same cycle and the partial word is discarded.
- Cycle sequence:
  - Cycle N (IDLE, req high): gnt pulses.
  - Cycles N+1 .. N+WIDTH: sout_valid = 1, carrying bits din[0] .. din[WIDTH-1] in order.
  - Cycle N+WIDTH+1: IDLE. The earliest next grant is in this cycle.
- Throughput is one word per WIDTH+1 cycles.
- If both requests are held continuously, grants alternate strictly (0, 1, 0, 1 …).

## Structure
- Package shift_ctrl_pkg contains:
  - state enum {IDLE, SHIFT};
  - 2-bit mode constants: HOLD = 2'b00, SHR = 2'b01, SHL = 2'b10, LOAD = 2'b11;
  - default WIDTH = 4.
- Sub-module universal_shift_reg:
  - parameter WIDTH;
  - ports clk, rst, mode, din, sin, q, q_bar;
  - async reset to 0; q_bar = ~q.
  - The controller instantiates it with sin = 0.
- The controller holds the FSM, arbiter pointer, bit_cnt, owner register and grant/mode decode.

## Test plan
- Reset, then req0=1 with din0=4'b1011:
  - gnt0 pulses once;
  - the next 4 cycles give sout = 1,1,0,1 with sout_valid=1 and owner=0;
  - then q=0000 and q_bar=1111.
- req0 and req1 both held, din0=4'b1001, din1=4'b0111:
  - grants in order gnt0, gnt1, gnt0;
  - sout streams 1,0,0,1 then 1,1,1,0;
  - each gnt is WIDTH+1 = 5 cycles apart.
- req1=1 during requester 0's SHIFT:
  - no gnt1 until IDLE;
  - gnt1 arrives exactly 1 cycle after the last sout_valid.
- rst asserted in the 2nd SHIFT cycle of 4'b1110:
  - q=0000, q_bar=1111 and sout_valid=0 immediately;
  - after release with req0 held, a fresh gnt0 and a full 4-bit stream follow.
- req0 pulsed for 1 cycle while busy:
  - no grant issued;
  - the controller returns to IDLE and holds q=0000.
- Parameter WIDTH=8 with din0=8'hA5:
  - 8 valid bits 1,0,1,0,0,1,0,1;
  - busy high for exactly 8 cycles.
